// File: rtl/matmul_pkg.sv
// Shared sizing defaults and scratchpad types for the matmul accelerator.
package matmul_pkg;

  localparam int BUS_WIDTH   = 16;
  localparam int MAX_DIM     = 4;
  localparam int SP_NTARGETS = 4;

  localparam int SP_TGT_W = $clog2(SP_NTARGETS);
  localparam int SP_IDX_W = $clog2(MAX_DIM);

  typedef enum logic [1:0] {
    SP_IDLE  = 2'd0,
    SP_ADD   = 2'd1,
    SP_WRITE = 2'd2
  } sp_state_t;

  typedef struct packed {
    logic [SP_TGT_W-1:0] target;
    logic [SP_IDX_W-1:0] row;
    logic [SP_IDX_W-1:0] col;
  } sp_addr_t;

  function automatic int unsigned sp_elem_idx(input int unsigned r, input int unsigned c);
    return r * MAX_DIM + c;
  endfunction

endpackage

// File: rtl/matmul_sp_accum.sv
// Element-wise signed wrap-around adder array with an OR-reduced overflow flag.
module matmul_sp_accum
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH = matmul_pkg::BUS_WIDTH,
  parameter int NELEM     = matmul_pkg::MAX_DIM * matmul_pkg::MAX_DIM
) (
  input  logic [BUS_WIDTH*NELEM-1:0] a_i,
  input  logic [BUS_WIDTH*NELEM-1:0] b_i,
  output logic [BUS_WIDTH*NELEM-1:0] sum_o,
  output logic                       ovf_o
);

  logic signed [BUS_WIDTH-1:0] a_el;
  logic signed [BUS_WIDTH-1:0] b_el;
  logic signed [BUS_WIDTH-1:0] s_el;

  // Overflow: operands share a sign that the truncated sum does not.
  always_comb begin
    sum_o = '0;
    ovf_o = 1'b0;
    a_el  = '0;
    b_el  = '0;
    s_el  = '0;
    for (int i = 0; i < NELEM; i++) begin
      a_el = a_i[i*BUS_WIDTH +: BUS_WIDTH];
      b_el = b_i[i*BUS_WIDTH +: BUS_WIDTH];
      s_el = a_el + b_el;
      sum_o[i*BUS_WIDTH +: BUS_WIDTH] = s_el;
      ovf_o = ovf_o | ((a_el[BUS_WIDTH-1] == b_el[BUS_WIDTH-1]) &&
                       (s_el[BUS_WIDTH-1] != a_el[BUS_WIDTH-1]));
    end
  end

endmodule

// File: rtl/matmul_scratchpad.sv
// Result scratchpad: register storage of result matrices with commit, element read and export.
// Define MATMUL_SP_ACCUM_EN to compile in the accumulate path, ADD state and overflow flag.
module matmul_scratchpad #(
  parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
  parameter int MAX_DIM     = matmul_pkg::MAX_DIM,
  parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            res_valid_i,
  output logic                                            res_ready_o,
  input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]            res_data_i,
  input  logic [$clog2(SP_NTARGETS)-1:0]                  res_target_i,
  input  logic                                            res_accum_i,
  input  logic [$clog2(SP_NTARGETS)-1:0]                  res_src_i,
  input  logic                                            rd_en_i,
  input  logic [$clog2(SP_NTARGETS)+2*$clog2(MAX_DIM)-1:0] rd_addr_i,
  output logic [BUS_WIDTH-1:0]                            rd_data_o,
  output logic                                            rd_valid_o,
  input  logic [$clog2(SP_NTARGETS)-1:0]                  exp_sel_i,
  output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]            data_sp_o,
  output logic                                            ovf_o,
  input  logic                                            ovf_clr_i
);
  import matmul_pkg::*;

  localparam int TGT_W = $clog2(SP_NTARGETS);
  localparam int IDX_W = $clog2(MAX_DIM);
  localparam int NEL   = MAX_DIM * MAX_DIM;
  localparam int MAT_W = BUS_WIDTH * NEL;

  localparam logic [1:0] ST_IDLE  = SP_IDLE;
  localparam logic [1:0] ST_WRITE = SP_WRITE;
`ifdef MATMUL_SP_ACCUM_EN
  localparam logic [1:0] ST_ADD   = SP_ADD;
`endif

  logic [1:0]       state_q, state_d;
  logic             xfer;
  logic [MAT_W-1:0] data_q;
  logic [TGT_W-1:0] tgt_q;
  logic [MAT_W-1:0] mem_q [SP_NTARGETS];

  logic [IDX_W-1:0]     rd_row, rd_col;
  logic [TGT_W-1:0]     rd_tgt;
  int                   rd_idx;
  logic [BUS_WIDTH-1:0] rd_word;
  logic [BUS_WIDTH-1:0] rd_data_q;
  logic                 rd_valid_q;

`ifdef MATMUL_SP_ACCUM_EN
  logic [TGT_W-1:0] src_q;
  logic [MAT_W-1:0] sum_w;
  logic             add_ovf_w;
  logic             ovf_q, ovf_d;
`endif

  assign res_ready_o = (state_q == ST_IDLE);
  assign xfer        = res_valid_i & res_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
`ifdef MATMUL_SP_ACCUM_EN
          state_d = res_accum_i ? ST_ADD : ST_WRITE;
`else
          state_d = ST_WRITE;
`endif
        end
      end
`ifdef MATMUL_SP_ACCUM_EN
      ST_ADD:   state_d = ST_WRITE;
`endif
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Transfer latch; the ADD cycle overwrites it in place with the registered sum.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      data_q <= res_data_i;
      tgt_q  <= res_target_i;
`ifdef MATMUL_SP_ACCUM_EN
      src_q  <= res_src_i;
`endif
    end
`ifdef MATMUL_SP_ACCUM_EN
    else if (state_q == ST_ADD) begin
      data_q <= sum_w;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < SP_NTARGETS; t++) mem_q[t] <= '0;
    end else if (state_q == ST_WRITE) begin
      mem_q[tgt_q] <= data_q;
    end
  end

  assign data_sp_o = mem_q[exp_sel_i];

  assign {rd_tgt, rd_row, rd_col} = rd_addr_i;

  always_comb begin
    rd_idx  = int'(rd_row) * MAX_DIM + int'(rd_col);
    rd_word = '0;
    if (rd_idx < NEL) rd_word = mem_q[rd_tgt][rd_idx*BUS_WIDTH +: BUS_WIDTH];
  end

  // Storage is sampled before the same-edge write lands, giving read-before-write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= rd_word;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

`ifdef MATMUL_SP_ACCUM_EN
  matmul_sp_accum #(
    .BUS_WIDTH (BUS_WIDTH),
    .NELEM     (NEL)
  ) u_accum (
    .a_i   (data_q),
    .b_i   (mem_q[src_q]),
    .sum_o (sum_w),
    .ovf_o (add_ovf_w)
  );

  // A set in the same edge as a clear wins.
  assign ovf_d = (ovf_q & ~ovf_clr_i) | ((state_q == ST_ADD) & add_ovf_w);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{res_accum_i, res_src_i, ovf_clr_i};
  assign ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_scratchpad.sv
// Directed self-checking bench for matmul_scratchpad; adapts expectations to MATMUL_SP_ACCUM_EN.
module tb_matmul_scratchpad;
  import matmul_pkg::*;

  localparam int MAT_W = BUS_WIDTH * MAX_DIM * MAX_DIM;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 res_valid = 1'b0;
  logic                 res_ready;
  logic [MAT_W-1:0]     res_data = '0;
  logic [1:0]           res_target = '0;
  logic                 res_accum = 1'b0;
  logic [1:0]           res_src = '0;
  logic                 rd_en = 1'b0;
  sp_addr_t             rd_addr = '0;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic [1:0]           exp_sel = '0;
  logic [MAT_W-1:0]     data_sp;
  logic                 ovf;
  logic                 ovf_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  matmul_scratchpad dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .res_valid_i  (res_valid),
    .res_ready_o  (res_ready),
    .res_data_i   (res_data),
    .res_target_i (res_target),
    .res_accum_i  (res_accum),
    .res_src_i    (res_src),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .exp_sel_i    (exp_sel),
    .data_sp_o    (data_sp),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAT_W-1:0] fill(input logic [BUS_WIDTH-1:0] v);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        m[sp_elem_idx(r, c)*BUS_WIDTH +: BUS_WIDTH] = v;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] diag(input logic [BUS_WIDTH-1:0] v);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < MAX_DIM; r++) m[sp_elem_idx(r, r)*BUS_WIDTH +: BUS_WIDTH] = v;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] one_at(input int r, input int c, input logic [BUS_WIDTH-1:0] v);
    logic [MAT_W-1:0] m;
    m = '0;
    m[sp_elem_idx(r, c)*BUS_WIDTH +: BUS_WIDTH] = v;
    return m;
  endfunction

  // Issues one transfer from IDLE and returns how many cycles ready stayed low (bounded).
  task automatic do_commit(input logic [MAT_W-1:0] d, input logic [1:0] tgt, input logic acc,
                           input logic [1:0] src, output int busy);
    res_data = d; res_target = tgt; res_accum = acc; res_src = src; res_valid = 1'b1;
    tick();
    res_valid = 1'b0; res_accum = 1'b0;
    busy = 0;
    for (int i = 0; i < 8 && !res_ready; i++) begin
      busy++;
      tick();
    end
  endtask

  task automatic do_read(input sp_addr_t a, output logic [BUS_WIDTH-1:0] d, output logic v1,
                         output logic v2, output logic [BUS_WIDTH-1:0] d_hold);
    rd_addr = a; rd_en = 1'b1;
    tick();
    d = rd_data; v1 = rd_valid;
    rd_en = 1'b0;
    tick();
    v2 = rd_valid; d_hold = rd_data;
  endtask

  task automatic test_reset();
    logic [BUS_WIDTH-1:0] d, dh;
    logic v1, v2;
    rst_n = 1'b0;
    tick(); tick();
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", res_ready); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    tick();
    exp_sel = 2'd2; #1;
    total++; if (data_sp !== '0) begin bad++; $display("FAIL reset_export got=%h exp=0", data_sp); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    do_read('{target: 2'd2, row: 2'd1, col: 2'd3}, d, v1, v2, dh);
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL reset_read_valid got=%b exp=1", v1); end
    total++; if (d !== '0) begin bad++; $display("FAIL reset_read_data got=%h exp=0", d); end
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL reset_read_pulse got=%b exp=0", v2); end
  endtask

  task automatic test_plain();
    int busy;
    logic [BUS_WIDTH-1:0] d, dh;
    logic v1, v2;
    do_commit(diag(16'd5), 2'd1, 1'b0, 2'd0, busy);
    total++; if (busy != 1) begin bad++; $display("FAIL plain_busy got=%0d exp=1", busy); end
    exp_sel = 2'd1; #1;
    total++; if (data_sp !== diag(16'd5)) begin bad++; $display("FAIL plain_export got=%h exp=%h", data_sp, diag(16'd5)); end
    exp_sel = 2'd0; #1;
    total++; if (data_sp !== '0) begin bad++; $display("FAIL plain_other_target got=%h exp=0", data_sp); end
    do_read('{target: 2'd1, row: 2'd2, col: 2'd2}, d, v1, v2, dh);
    total++; if (d !== 16'd5 || v1 !== 1'b1) begin bad++; $display("FAIL plain_read_diag got=%h/%b exp=5/1", d, v1); end
    total++; if (v2 !== 1'b0 || dh !== 16'd5) begin bad++; $display("FAIL plain_read_hold got=%h/%b exp=5/0", dh, v2); end
    do_read('{target: 2'd1, row: 2'd2, col: 2'd3}, d, v1, v2, dh);
    total++; if (d !== 16'd0) begin bad++; $display("FAIL plain_read_offdiag got=%h exp=0", d); end
    do_commit(one_at(1, 2, 16'h1234), 2'd3, 1'b0, 2'd0, busy);
    exp_sel = 2'd3; #1;
    total++; if (data_sp !== one_at(1, 2, 16'h1234)) begin bad++; $display("FAIL plain_export_rc got=%h exp=%h", data_sp, one_at(1, 2, 16'h1234)); end
    do_read('{target: 2'd3, row: 2'd1, col: 2'd2}, d, v1, v2, dh);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL plain_read_rc got=%h exp=1234", d); end
    do_read('{target: 2'd3, row: 2'd2, col: 2'd1}, d, v1, v2, dh);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL plain_read_cr got=%h exp=0", d); end
  endtask

  task automatic test_accum();
    int busy;
    do_commit(fill(16'd3), 2'd0, 1'b0, 2'd0, busy);
    do_commit(fill(16'hFFF9), 2'd2, 1'b1, 2'd0, busy);
    exp_sel = 2'd2; #1;
`ifdef MATMUL_SP_ACCUM_EN
    total++; if (busy != 2) begin bad++; $display("FAIL accum_busy got=%0d exp=2", busy); end
    total++; if (data_sp !== fill(16'hFFFC)) begin bad++; $display("FAIL accum_result got=%h exp=%h", data_sp, fill(16'hFFFC)); end
`else
    total++; if (busy != 1) begin bad++; $display("FAIL accum_ignored_busy got=%0d exp=1", busy); end
    total++; if (data_sp !== fill(16'hFFF9)) begin bad++; $display("FAIL accum_ignored_result got=%h exp=%h", data_sp, fill(16'hFFF9)); end
`endif
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL accum_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_overflow();
    int busy;
    do_commit(one_at(0, 0, 16'h7FFF), 2'd0, 1'b0, 2'd0, busy);
    do_commit(one_at(0, 0, 16'h0001), 2'd0, 1'b1, 2'd0, busy);
    exp_sel = 2'd0; #1;
`ifdef MATMUL_SP_ACCUM_EN
    total++; if (data_sp !== one_at(0, 0, 16'h8000)) begin bad++; $display("FAIL ovf_wrap got=%h exp=%h", data_sp, one_at(0, 0, 16'h8000)); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    tick(); tick();
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    ovf_clr = 1'b1;
    res_data = one_at(0, 0, 16'hFFFF); res_target = 2'd0; res_src = 2'd0; res_accum = 1'b1; res_valid = 1'b1;
    tick();
    res_valid = 1'b0; res_accum = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre_add got=%b exp=0", ovf); end
    tick();
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", ovf); end
    tick();
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_after got=%b exp=0", ovf); end
    ovf_clr = 1'b0;
    total++; if (data_sp !== one_at(0, 0, 16'h7FFF)) begin bad++; $display("FAIL ovf_neg_wrap got=%h exp=%h", data_sp, one_at(0, 0, 16'h7FFF)); end
`else
    total++; if (data_sp !== one_at(0, 0, 16'h0001)) begin bad++; $display("FAIL ovf_ignored_data got=%h exp=%h", data_sp, one_at(0, 0, 16'h0001)); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_tied got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_collision();
    int busy;
    do_commit(diag(16'd5), 2'd1, 1'b0, 2'd0, busy);
    res_data = fill(16'd9); res_target = 2'd1; res_accum = 1'b0; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL coll_busy got=%b exp=0", res_ready); end
    rd_addr = '{target: 2'd1, row: 2'd0, col: 2'd0}; rd_en = 1'b1;
    tick();
    total++; if (rd_data !== 16'd5 || rd_valid !== 1'b1) begin bad++; $display("FAIL coll_old got=%h/%b exp=5/1", rd_data, rd_valid); end
    exp_sel = 2'd1; #1;
    total++; if (data_sp !== fill(16'd9)) begin bad++; $display("FAIL coll_export got=%h exp=%h", data_sp, fill(16'd9)); end
    tick();
    rd_en = 1'b0;
    total++; if (rd_data !== 16'd9) begin bad++; $display("FAIL coll_new got=%h exp=9", rd_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    res_data = fill(16'd11); res_target = 2'd3; res_accum = 1'b1; res_src = 2'd3; res_valid = 1'b1;
    tick();
    res_valid = 1'b0; res_accum = 1'b0;
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", res_ready); end
    rst_n = 1'b0; #1;
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL rstmid_async_idle got=%b exp=1", res_ready); end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    exp_sel = 2'd3; #1;
    total++; if (data_sp !== '0) begin bad++; $display("FAIL rstmid_no_write got=%h exp=0", data_sp); end
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b exp=1", res_ready); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    res_data = fill(16'd4); res_target = 2'd2; res_accum = 1'b0; res_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_ready) accepts++;
      tick();
    end
    res_valid = 1'b0;
    total++; if (accepts != 3) begin bad++; $display("FAIL b2b_plain_accepts got=%0d exp=3", accepts); end
    exp_sel = 2'd2; #1;
    total++; if (data_sp !== fill(16'd4)) begin bad++; $display("FAIL b2b_plain_data got=%h exp=%h", data_sp, fill(16'd4)); end
    res_data = fill(16'd1); res_target = 2'd2; res_src = 2'd2; res_accum = 1'b1; res_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_ready) accepts++;
      tick();
    end
    res_valid = 1'b0; res_accum = 1'b0;
    #1;
`ifdef MATMUL_SP_ACCUM_EN
    total++; if (accepts != 2) begin bad++; $display("FAIL b2b_accum_accepts got=%0d exp=2", accepts); end
    total++; if (data_sp !== fill(16'd6)) begin bad++; $display("FAIL b2b_accum_data got=%h exp=%h", data_sp, fill(16'd6)); end
`else
    total++; if (accepts != 3) begin bad++; $display("FAIL b2b_noaccum_accepts got=%0d exp=3", accepts); end
    total++; if (data_sp !== fill(16'd1)) begin bad++; $display("FAIL b2b_noaccum_data got=%h exp=%h", data_sp, fill(16'd1)); end
`endif
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", res_ready); end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_accum();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
